// File: rtl/i_wishbone_master.sv
// Pipelined Wishbone B4 master engine.
// Turns a stream of commands into pipelined bus cycles and returns one response per
// command, in issue order.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o  command handshake (accepted on valid & ready)
//   cmd_we_i, cmd_last_i       write flag, last transfer of the bus cycle
//   cmd_adr_i/sel_i/dat_i      address, byte select, write data
//   rsp_valid_o                one-cycle pulse per completed transfer
//   rsp_dat_o                  read data captured on read acks
//   rsp_err_o                  transfer ended by err or by timeout
//   busy_o                     cyc active or transfers outstanding
//   wb_*                       Wishbone B4 pipelined master interface (outputs registered)
module i_wishbone_master #(
  parameter int unsigned g_addr_width      = 32,
  parameter int unsigned g_data_width      = 32,
  parameter int unsigned g_max_outstanding = 16,
  parameter int unsigned g_cyc_on_stall    = 1,
  parameter int unsigned g_timeout         = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic                      cmd_last_i,
  input  logic [g_addr_width-1:0]   cmd_adr_i,
  input  logic [g_data_width/8-1:0] cmd_sel_i,
  input  logic [g_data_width-1:0]   cmd_dat_i,
  output logic                      rsp_valid_o,
  output logic [g_data_width-1:0]   rsp_dat_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [g_addr_width-1:0]   wb_adr_o,
  output logic [g_data_width/8-1:0] wb_sel_o,
  output logic [g_data_width-1:0]   wb_dat_o,
  input  logic [g_data_width-1:0]   wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_stall_i
);

  localparam int unsigned SelW = g_data_width / 8;
  localparam int unsigned CntW = $clog2(g_max_outstanding + 1);
  localparam int unsigned TmrW = $clog2(g_timeout + 1);

  typedef enum logic [1:0] {StIdle, StBus, StDrain, StAbort} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          out_q, out_d;
  logic [TmrW-1:0]          tmr_q, tmr_d;
  // Write flag of each outstanding beat, oldest in bit 0; selects read-data capture.
  logic [g_max_outstanding-1:0] we_pend_q, we_pend_d;
  logic                     last_q, last_d;
  logic                     cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [g_addr_width-1:0]  adr_q, adr_d;
  logic [SelW-1:0]          sel_q, sel_d;
  logic [g_data_width-1:0]  dat_q, dat_d;
  logic                     rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [g_data_width-1:0]  rsp_dat_q, rsp_dat_d;

  logic issue, resp, room, accept;
  logic [CntW-1:0] push_idx;

  assign issue  = stb_q & ~wb_stall_i;
  // Responses with nothing outstanding are spurious and dropped.
  assign resp   = (wb_ack_i | wb_err_i) & (out_q != '0) & (state_q != StAbort);
  assign room   = (32'(out_q) + 32'(stb_q)) < g_max_outstanding;
  // A pending last beat closes the cycle, so nothing may be queued behind it.
  assign cmd_ready_o = (~stb_q | ~wb_stall_i) & room & ~(stb_q & last_q) &
                       ((state_q == StIdle) | (state_q == StBus));
  assign accept = cmd_valid_i & cmd_ready_o;
  assign push_idx = out_q - CntW'(resp);

  always_comb begin
    state_d     = state_q;
    tmr_d       = '0;
    last_d      = last_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    out_d       = out_q + CntW'(issue) - CntW'(resp);
    we_pend_d   = resp ? (we_pend_q >> 1) : we_pend_q;
    for (int unsigned i = 0; i < g_max_outstanding; i++) begin
      if (issue && (i == 32'(push_idx))) we_pend_d[i] = we_q;
    end

    if (resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = wb_err_i;
      if (wb_ack_i && !wb_err_i && !we_pend_q[0]) rsp_dat_d = wb_dat_i;
    end

    if (accept) begin
      adr_d  = cmd_adr_i;
      sel_d  = cmd_sel_i;
      dat_d  = cmd_dat_i;
      we_d   = cmd_we_i;
      last_d = cmd_last_i;
      stb_d  = 1'b1;
      cyc_d  = 1'b1;
    end else if (issue) begin
      stb_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StBus;
      end
      StBus: begin
        if (issue && last_q) begin
          state_d = StDrain;
        end else if ((g_cyc_on_stall == 0) && !accept && !stb_q && (out_q == '0)) begin
          cyc_d = 1'b0;
        end
      end
      StDrain: begin
        tmr_d = resp ? '0 : tmr_q + TmrW'(1);
        if (out_q == '0) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          tmr_d   = '0;
        end else if (!resp && (tmr_q == TmrW'(g_timeout - 1))) begin
          state_d = StAbort;
          cyc_d   = 1'b0;
          tmr_d   = '0;
        end
      end
      StAbort: begin
        // Flush one error response per abandoned beat.
        if (out_q != '0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          out_d       = out_q - CntW'(1);
        end
        if (out_q <= CntW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      out_q       <= '0;
      tmr_q       <= '0;
      we_pend_q   <= '0;
      last_q      <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      tmr_q       <= tmr_d;
      we_pend_q   <= we_pend_d;
      last_q      <= last_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign busy_o      = cyc_q | (out_q != '0);

endmodule

// File: tb/tb_i_wishbone_master.sv
// Self-checking bench for i_wishbone_master: a command queue feeds the DUT, a
// queue-based slave answers issued beats, and expected responses are derived
// from the order beats were accepted and acknowledged.
module tb_i_wishbone_master;

  localparam int unsigned Aw = 32;
  localparam int unsigned Dw = 32;
  localparam int unsigned MaxOut = 4;
  localparam int unsigned Tmo = 40;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0, cmd_last_i = 1'b0;
  logic [Aw-1:0] cmd_adr_i = '0;
  logic [Dw/8-1:0] cmd_sel_i = '0;
  logic [Dw-1:0] cmd_dat_i = '0;
  logic rsp_valid_o, rsp_err_o, busy_o;
  logic [Dw-1:0] rsp_dat_o;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [Aw-1:0] wb_adr_o;
  logic [Dw/8-1:0] wb_sel_o;
  logic [Dw-1:0] wb_dat_o;
  logic [Dw-1:0] wb_dat_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;

  always #5 clk_i = ~clk_i;

  i_wishbone_master #(
    .g_addr_width     (Aw),
    .g_data_width     (Dw),
    .g_max_outstanding(MaxOut),
    .g_cyc_on_stall   (1),
    .g_timeout        (Tmo)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_last_i (cmd_last_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_sel_i  (cmd_sel_i),
    .cmd_dat_i  (cmd_dat_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .busy_o     (busy_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_stall_i (wb_stall_i)
  );

  typedef struct packed {
    logic          we;
    logic          last;
    logic [Aw-1:0] adr;
    logic [3:0]    sel;
    logic [Dw-1:0] dat;
  } cmd_t;
  typedef struct {
    logic          we;
    logic [Aw-1:0] adr;
    int            due;
    logic          err;
  } beat_t;
  typedef struct {
    logic          err;
    logic          chk_dat;
    logic [Dw-1:0] dat;
  } rsp_t;

  cmd_t  todo_q[$];
  cmd_t  acc_q[$];
  beat_t pend_q[$];
  rsp_t  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int tick_n = 0;
  int stall_pct = 0, gap_pct = 0, ack_dly = 0;
  int issued = 0, issue_first = 0, issue_last = 0, n_rsp = 0, first_rsp = -1;
  logic withhold = 1'b0, err_en = 1'b0;
  logic [Aw-1:0] err_adr = '0;
  logic [Dw-1:0] last_rdat = '0;
  logic hold_prev = 1'b0;
  logic [Aw-1:0] prev_adr = '0;
  logic [Dw-1:0] prev_dat = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [Dw-1:0] rdat(input logic [Aw-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: drive at the falling edge, then evaluate what the next rising edge does.
  task automatic tick();
    cmd_t c;
    beat_t b;
    rsp_t e;
    @(negedge clk_i);
    tick_n++;
    if (todo_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      cmd_valid_i = 1'b1;
      cmd_we_i    = todo_q[0].we;
      cmd_last_i  = todo_q[0].last;
      cmd_adr_i   = todo_q[0].adr;
      cmd_sel_i   = todo_q[0].sel;
      cmd_dat_i   = todo_q[0].dat;
    end else begin
      cmd_valid_i = 1'b0;
    end
    wb_stall_i = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = $urandom;
    if (!withhold && pend_q.size() > 0 && pend_q[0].due <= tick_n) begin
      if (pend_q[0].err) wb_err_i = 1'b1;
      else wb_ack_i = 1'b1;
      if (!pend_q[0].we) wb_dat_i = rdat(pend_q[0].adr);
    end
    #1;
    if (rsp_valid_o) begin
      if (first_rsp < 0) first_rsp = tick_n;
      if (exp_q.size() == 0) begin
        check("rsp_extra", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        n_rsp++;
        check("rsp_err", rsp_err_o, e.err);
        if (e.chk_dat) check("rsp_dat", rsp_dat_o, e.dat);
      end
    end
    if (hold_prev) begin
      check("hold_stb", wb_stb_o, 1'b1);
      check("hold_adr", wb_adr_o, prev_adr);
      check("hold_dat", wb_dat_o, prev_dat);
    end
    hold_prev = wb_stb_o && wb_stall_i;
    prev_adr  = wb_adr_o;
    prev_dat  = wb_dat_o;
    if (wb_stb_o && !wb_stall_i) begin
      if (acc_q.size() == 0) begin
        check("issue_extra", 1'b1, 1'b0);
      end else begin
        c = acc_q.pop_front();
        check("iss_adr", wb_adr_o, c.adr);
        check("iss_we", wb_we_o, c.we);
        check("iss_sel", wb_sel_o, c.sel);
        if (c.we) check("iss_dat", wb_dat_o, c.dat);
        check("iss_cyc", wb_cyc_o, 1'b1);
        b.we  = c.we;
        b.adr = c.adr;
        b.due = tick_n + ((ack_dly > 0) ? ack_dly : int'($urandom_range(1, 3)));
        b.err = err_en && (c.adr == err_adr);
        pend_q.push_back(b);
        issued++;
        if (issued == 1) issue_first = tick_n;
        issue_last = tick_n;
      end
    end
    if (cmd_valid_i && cmd_ready_o) acc_q.push_back(todo_q.pop_front());
    if (wb_ack_i || wb_err_i) begin
      b = pend_q.pop_front();
      if (!b.we && wb_ack_i) last_rdat = wb_dat_i;
      e.err = wb_err_i;
      e.chk_dat = 1'b1;
      e.dat = last_rdat;
      exp_q.push_back(e);
    end
  endtask

  // mode: 0 read, 1 write, 2 random direction.
  task automatic add_burst(input int n, input int mode, input logic [Aw-1:0] base);
    cmd_t c;
    for (int i = 0; i < n; i++) begin
      c.we   = (mode == 2) ? 1'($urandom_range(1)) : 1'(mode);
      c.last = (i == n - 1);
      c.adr  = base + Aw'(4 * i);
      c.sel  = 4'($urandom_range(1, 15));
      c.dat  = $urandom;
      todo_q.push_back(c);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int t = 0;
    while ((todo_q.size() + acc_q.size() + pend_q.size() + exp_q.size()) > 0 && t < budget) begin
      tick();
      t++;
    end
    check({tag, "_done"}, (t < budget), 1'b1);
    repeat (4) tick();
    check({tag, "_cyc"}, wb_cyc_o, 1'b0);
    check({tag, "_stb"}, wb_stb_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk_i);
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_stall_i = 1'b0;
    @(negedge clk_i);
    #1;
    check({tag, "_cyc"}, wb_cyc_o, 1'b0);
    check({tag, "_stb"}, wb_stb_o, 1'b0);
    check({tag, "_we"}, wb_we_o, 1'b0);
    check({tag, "_adr"}, wb_adr_o, '0);
    check({tag, "_sel"}, wb_sel_o, '0);
    check({tag, "_dat"}, wb_dat_o, '0);
    check({tag, "_rsp_v"}, rsp_valid_o, 1'b0);
    check({tag, "_rsp_e"}, rsp_err_o, 1'b0);
    check({tag, "_rsp_d"}, rsp_dat_o, '0);
    check({tag, "_busy"}, busy_o, 1'b0);
    rst_i = 1'b0;
    todo_q.delete();
    acc_q.delete();
    pend_q.delete();
    exp_q.delete();
    last_rdat = '0;
    hold_prev = 1'b0;
  endtask

  initial begin
    cmd_t c;
    rsp_t e;
    int t;
    repeat (3) @(negedge clk_i);
    reset_check("reset");

    // Single write, acked one clock after issue.
    ack_dly = 1;
    c = '{we: 1'b1, last: 1'b1, adr: 32'h8, sel: 4'hF, dat: 32'hFFFF_FFFF};
    todo_q.push_back(c);
    issued = 0;
    n_rsp = 0;
    drain("wr1", 50);
    check("wr1_nrsp", n_rsp, 1);

    // Four-beat pipelined read, no stall, acks two clocks after each strobe.
    ack_dly = 2;
    issued = 0;
    n_rsp = 0;
    add_burst(4, 0, 32'h40);
    drain("rd4", 60);
    check("rd4_nrsp", n_rsp, 4);
    check("rd4_back2back", issue_last - issue_first, 3);

    // Long burst under random stalls and gaps.
    ack_dly = 0;
    stall_pct = 50;
    gap_pct = 20;
    issued = 0;
    n_rsp = 0;
    add_burst(750, 2, 32'h1000);
    drain("rnd", 20000);
    check("rnd_nrsp", n_rsp, 750);
    check("rnd_issued", issued, 750);
    stall_pct = 0;
    gap_pct = 0;

    // Outstanding limit: acks withheld, only MaxOut beats may issue.
    withhold = 1'b1;
    issued = 0;
    n_rsp = 0;
    add_burst(6, 0, 32'h300);
    repeat (20) tick();
    check("max_issued", issued, MaxOut);
    check("max_ready", cmd_ready_o, 1'b0);
    check("max_busy", busy_o, 1'b1);
    withhold = 1'b0;
    drain("max", 100);
    check("max_nrsp", n_rsp, 6);

    // Error on the second of three beats.
    err_en = 1'b1;
    err_adr = 32'h104;
    n_rsp = 0;
    add_burst(3, 0, 32'h100);
    drain("err", 60);
    check("err_nrsp", n_rsp, 3);
    err_en = 1'b0;

    // Timeout in DRAIN with three outstanding beats.
    withhold = 1'b1;
    issued = 0;
    add_burst(3, 1, 32'h200);
    t = 0;
    while ((todo_q.size() + acc_q.size()) > 0 && t < 50) begin
      tick();
      t++;
    end
    check("to_issued", pend_q.size(), 3);
    pend_q.delete();
    e.err = 1'b1;
    e.chk_dat = 1'b0;
    e.dat = '0;
    repeat (3) exp_q.push_back(e);
    first_rsp = -1;
    n_rsp = 0;
    t = 0;
    while (exp_q.size() > 0 && t < int'(Tmo) + 50) begin
      tick();
      t++;
    end
    check("to_done", (exp_q.size() == 0), 1'b1);
    check("to_not_early", (first_rsp - issue_last >= int'(Tmo)), 1'b1);
    check("to_not_late", (first_rsp - issue_last <= int'(Tmo) + 4), 1'b1);
    repeat (3) tick();
    check("to_cyc", wb_cyc_o, 1'b0);
    check("to_busy", busy_o, 1'b0);
    withhold = 1'b0;

    // Reset in the middle of a burst, then confirm normal operation resumes.
    add_burst(8, 1, 32'h500);
    repeat (5) tick();
    reset_check("midrst");
    n_rsp = 0;
    add_burst(2, 0, 32'h600);
    drain("post", 60);
    check("post_nrsp", n_rsp, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
